// File: rtl/ycc_stream_sequencer.sv
// Frame sequencer for the component-serial pixel core: splits YCbCr pixels into
// Y/Cr/Cb byte beats toward the core and regroups returning beats into pixels.
module ycc_stream_sequencer #(
  parameter int PIXELS = 256060,
  parameter int CNT_W  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        s_pix_tvalid,
  output logic        s_pix_tready,
  input  logic [23:0] s_pix_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic [1:0]  m_axis_tuser,
  output logic        m_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [7:0]  s_axis_tdata,
  output logic        m_pix_tvalid,
  input  logic        m_pix_tready,
  output logic [23:0] m_pix_tdata,
  output logic        m_pix_tlast
);

  // state   | meaning
  // TX_IDLE | no beat pending, may take a pixel
  // TX_Y    | presenting Y byte
  // TX_CR   | presenting Cr byte
  // TX_CB   | presenting Cb byte, next pixel may be taken on its handshake
  typedef enum logic [1:0] {TX_IDLE, TX_Y, TX_CR, TX_CB} txState_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIXELS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  txState_t         txState;
  logic [23:0]      pixReg;
  logic [CNT_W-1:0] txCnt;
  logic [CNT_W-1:0] rxCnt;
  logic [1:0]       rxPhase;
  logic [7:0]       yReg;
  logic [7:0]       crReg;
  logic             pixAccept;
  logic             beatXfer;
  logic             rxXfer;
  logic             pixOut;
  logic             frameStart;

  assign frameStart    = start && !busy;
  assign beatXfer      = m_axis_tvalid && m_axis_tready;
  assign s_pix_tready  = busy && (txCnt < LAST_CNT) &&
                         (txState == TX_IDLE || (txState == TX_CB && m_axis_tready));
  assign pixAccept     = s_pix_tvalid && s_pix_tready;
  assign s_axis_tready = busy && (rxPhase != 2'd2 || !m_pix_tvalid || m_pix_tready);
  assign rxXfer        = s_axis_tvalid && s_axis_tready;
  assign pixOut        = m_pix_tvalid && m_pix_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      txState       <= TX_IDLE;
      pixReg        <= '0;
      txCnt         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (frameStart) txCnt <= '0;
      // A pixel taken during the Cb handshake chains straight into Y, no bubble.
      if (pixAccept) begin
        txState       <= TX_Y;
        pixReg        <= s_pix_tdata;
        txCnt         <= txCnt + CNT_ONE;
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_pix_tdata[23:16];
        m_axis_tuser  <= 2'd0;
        m_axis_tlast  <= 1'b0;
      end else begin
        case (txState)
          TX_Y: if (beatXfer) begin
            txState      <= TX_CR;
            m_axis_tdata <= pixReg[15:8];
            m_axis_tuser <= 2'd1;
          end
          TX_CR: if (beatXfer) begin
            txState      <= TX_CB;
            m_axis_tdata <= pixReg[7:0];
            m_axis_tuser <= 2'd2;
            m_axis_tlast <= (txCnt == LAST_CNT);
          end
          TX_CB: if (beatXfer) begin
            txState       <= TX_IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
          end
          default: txState <= TX_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      rxCnt        <= '0;
      rxPhase      <= 2'd0;
      yReg         <= '0;
      crReg        <= '0;
      m_pix_tvalid <= 1'b0;
      m_pix_tdata  <= '0;
      m_pix_tlast  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (frameStart) begin
        busy    <= 1'b1;
        rxCnt   <= '0;
        rxPhase <= 2'd0;
      end else if (pixOut && m_pix_tlast) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
      if (pixOut) begin
        m_pix_tvalid <= 1'b0;
        m_pix_tlast  <= 1'b0;
      end
      if (rxXfer) begin
        case (rxPhase)
          2'd0:    yReg  <= s_axis_tdata;
          2'd1:    crReg <= s_axis_tdata;
          default: begin
            m_pix_tvalid <= 1'b1;
            m_pix_tdata  <= {yReg, crReg, s_axis_tdata};
            m_pix_tlast  <= (rxCnt + CNT_ONE == LAST_CNT);
            rxCnt        <= rxCnt + CNT_ONE;
          end
        endcase
        rxPhase <= (rxPhase == 2'd2) ? 2'd0 : rxPhase + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_ycc_stream_sequencer.sv
// Scoreboard bench for ycc_stream_sequencer with a 4-pixel frame and the core
// modelled as a gated loopback from m_axis to s_axis.
module tb_ycc_stream_sequencer;
  localparam int PIXELS = 4;

  logic        clk = 1'b0;
  logic        rst, start, busy, done;
  logic        s_pix_tvalid, s_pix_tready;
  logic [23:0] s_pix_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [7:0]  m_axis_tdata;
  logic [1:0]  m_axis_tuser;
  logic        s_axis_tvalid, s_axis_tready;
  logic [7:0]  s_axis_tdata;
  logic        m_pix_tvalid, m_pix_tready, m_pix_tlast;
  logic [23:0] m_pix_tdata;

  logic coreGate, coreEn, toggleMode, sinkReady, watchReady;

  always #5 clk = ~clk;

  assign m_axis_tready = s_axis_tready && coreGate;
  assign s_axis_tvalid = m_axis_tvalid && coreGate;
  assign s_axis_tdata  = m_axis_tdata;
  assign m_pix_tready  = sinkReady;

  ycc_stream_sequencer #(.PIXELS(PIXELS), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .s_pix_tvalid(s_pix_tvalid), .s_pix_tready(s_pix_tready), .s_pix_tdata(s_pix_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_pix_tvalid(m_pix_tvalid), .m_pix_tready(m_pix_tready), .m_pix_tdata(m_pix_tdata),
    .m_pix_tlast(m_pix_tlast)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beatCnt = 0, pixCnt = 0, doneCnt = 0;
  int firstBeatCyc = 0, lastBeatCyc = 0, lastPixCyc = -10;
  logic [23:0] srcQ[$];
  logic [10:0] expBeat[$];
  logic [24:0] expPix[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushPixel(input logic [23:0] p, input logic last);
    srcQ.push_back(p);
    expBeat.push_back({p[23:16], 2'd0, 1'b0});
    expBeat.push_back({p[15:8],  2'd1, 1'b0});
    expBeat.push_back({p[7:0],   2'd2, last});
    expPix.push_back({p, last});
  endtask

  task automatic pushFrame(input logic [23:0] a, input logic [23:0] b,
                           input logic [23:0] c, input logic [23:0] d);
    pushPixel(a, 1'b0);
    pushPixel(b, 1'b0);
    pushPixel(c, 1'b0);
    pushPixel(d, 1'b1);
  endtask

  task automatic pulseStart();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget, input string name);
    int n = 0;
    while (doneCnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_done_seen"}, doneCnt, target);
    @(negedge clk);
    check({name, "_done_single"}, done, 1'b0);
    check({name, "_busy_after"}, busy, 1'b0);
  endtask

  // Source driver: presents the head of srcQ, popped by the monitor on handshake.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (srcQ.size() > 0) begin
        s_pix_tvalid = 1'b1;
        s_pix_tdata  = srcQ[0];
      end else begin
        s_pix_tvalid = 1'b0;
        s_pix_tdata  = '0;
      end
      if (toggleMode) coreGate = ~coreGate;
      else            coreGate = coreEn;
    end
  end

  // Monitor: sampled on the falling edge; a handshake seen here lands on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_axis_tvalid && m_axis_tready) begin
          if (expBeat.size() == 0) begin
            checks++; errors++;
            $display("FAIL beat_unexpected: got %0h expected none", {m_axis_tdata, m_axis_tuser, m_axis_tlast});
          end else check("beat", {m_axis_tdata, m_axis_tuser, m_axis_tlast}, expBeat.pop_front());
          if (beatCnt == 0) firstBeatCyc = cyc;
          lastBeatCyc = cyc;
          beatCnt++;
        end
        if (m_pix_tvalid && m_pix_tready) begin
          if (expPix.size() == 0) begin
            checks++; errors++;
            $display("FAIL pix_unexpected: got %0h expected none", {m_pix_tdata, m_pix_tlast});
          end else check("pix", {m_pix_tdata, m_pix_tlast}, expPix.pop_front());
          if (m_pix_tlast) lastPixCyc = cyc;
          pixCnt++;
        end
        if (done) begin
          doneCnt++;
          check("done_after_last_pix", cyc, lastPixCyc + 1);
          check("busy_low_with_done", busy, 1'b0);
        end
        if (watchReady && s_pix_tready)
          check("spix_ready_slot", (!m_axis_tvalid) || (m_axis_tuser == 2'd2 && m_axis_tready), 1'b1);
        if (s_pix_tvalid && s_pix_tready && srcQ.size() > 0) void'(srcQ.pop_front());
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; coreEn = 1'b1; coreGate = 1'b1; toggleMode = 1'b0;
    sinkReady = 1'b1; watchReady = 1'b0; s_pix_tvalid = 1'b0; s_pix_tdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy_done", {busy, done}, 2'b00);
    check("reset_valids", {m_axis_tvalid, m_pix_tvalid, m_axis_tlast, m_pix_tlast}, 4'b0000);
    check("reset_readys", {s_pix_tready, s_axis_tready}, 2'b00);
    @(posedge clk); #1 rst = 1'b0;

    // Source valid with no frame started: nothing must move.
    pushFrame(24'h102030, 24'h405060, 24'h708090, 24'hA0B0C0);
    repeat (5) begin
      @(negedge clk);
      check("idle_spix_ready", s_pix_tready, 1'b0);
      check("idle_maxis_valid", m_axis_tvalid, 1'b0);
    end

    // Frame 1: full-rate loopback.
    beatCnt = 0; pixCnt = 0;
    pulseStart();
    waitDone(1, 200, "f1");
    check("f1_beats", beatCnt, 12);
    check("f1_back_to_back", lastBeatCyc - firstBeatCyc, 11);
    check("f1_pixels", pixCnt, PIXELS);

    // Frame 2: core ready toggling every cycle.
    beatCnt = 0; pixCnt = 0; toggleMode = 1'b1; watchReady = 1'b1;
    pushFrame(24'h112233, 24'h445566, 24'h778899, 24'hAABBCC);
    pulseStart();
    waitDone(2, 400, "f2");
    check("f2_beats", beatCnt, 12);
    check("f2_pixels", pixCnt, PIXELS);
    toggleMode = 1'b0; watchReady = 1'b0;

    // Frame 3: sink stalls after the first pixel.
    beatCnt = 0; pixCnt = 0;
    pushFrame(24'h0A0B0C, 24'h1D2E3F, 24'h4A5B6C, 24'h7D8E9F);
    pulseStart();
    n = 0;
    while (pixCnt < 1 && n < 100) begin @(posedge clk); n++; end
    check("f3_first_pix_seen", pixCnt, 1);
    #1 sinkReady = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("f3_stall_beats", beatCnt, 8);
    check("f3_stall_rx_ready", s_axis_tready, 1'b0);
    check("f3_held_valid", m_pix_tvalid, 1'b1);
    check("f3_held_data", m_pix_tdata, 24'h1D2E3F);
    check("f3_stall_pixels", pixCnt, 1);
    @(posedge clk); #1 sinkReady = 1'b1;
    waitDone(3, 200, "f3");
    check("f3_beats", beatCnt, 12);
    check("f3_pixels", pixCnt, PIXELS);

    // Frame 4: a second start mid-frame is ignored.
    beatCnt = 0; pixCnt = 0;
    pushFrame(24'h010203, 24'h040506, 24'h070809, 24'hFFEEDD);
    pulseStart();
    repeat (3) @(posedge clk);
    pulseStart();
    waitDone(4, 200, "f4");
    check("f4_beats", beatCnt, 12);
    check("f4_pixels", pixCnt, PIXELS);

    // Reset after five beats, then a clean frame.
    beatCnt = 0; pixCnt = 0;
    pushPixel(24'hDEADBE, 1'b0);
    pushPixel(24'h123456, 1'b0);
    pulseStart();
    n = 0;
    while (beatCnt < 5 && n < 100) begin @(posedge clk); n++; end
    check("rst_five_beats", beatCnt, 5);
    #1 rst = 1'b1; coreEn = 1'b0; coreGate = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy_done", {busy, done}, 2'b00);
    check("rst_mid_valids", {m_axis_tvalid, m_pix_tvalid, m_axis_tlast, m_pix_tlast}, 4'b0000);
    check("rst_mid_readys", {s_pix_tready, s_axis_tready}, 2'b00);
    check("rst_mid_beats_left", expBeat.size(), 1);
    check("rst_mid_pix_left", expPix.size(), 1);
    check("rst_mid_no_done", doneCnt, 4);
    expBeat.delete();
    expPix.delete();
    @(posedge clk); #1 rst = 1'b0; coreEn = 1'b1;
    beatCnt = 0; pixCnt = 0;
    pushFrame(24'hC0FFEE, 24'hBADA55, 24'h00FF00, 24'hFEDCBA);
    pulseStart();
    waitDone(5, 200, "f5");
    check("f5_beats", beatCnt, 12);
    check("f5_pixels", pixCnt, PIXELS);

    repeat (3) @(posedge clk);
    check("end_beat_queue", expBeat.size(), 0);
    check("end_pix_queue", expPix.size(), 0);
    check("end_src_queue", srcQ.size(), 0);
    check("end_done_count", doneCnt, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ycc_stream_sequencer.md
Name: ycc_stream_sequencer

Overview:
- Frame-level controller for the 8-bit component-serial pixel core (AXI-stream in/out, one byte per beat).
- TX side: takes whole 24-bit YCbCr pixels and serializes each into 3 beats in fixed order Y, Cr, Cb. Tags each beat and marks the frame's last beat.
- RX side: regroups the core's output beats into 24-bit pixels. Counts pixels per frame, raises done when the whole frame has returned.
- Sits between the pixel source/sink (BMP loader, DMA) and the processing core.

Parameters:
PIXELS, 256060, pixels per frame (620x413)
CNT_W, 18, pixel counter width; must satisfy 2^CNT_W > PIXELS

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse, begins a frame
busy  out  1  frame in progress
done  out  1  one-cycle pulse, last pixel returned
s_pix_tvalid  in  1  source pixel valid
s_pix_tready  out  1  source pixel ready
s_pix_tdata  in  24  {Y[23:16], Cr[15:8], Cb[7:0]}
m_axis_tvalid  out  1  beat to core valid
m_axis_tready  in  1  core ready
m_axis_tdata  out  8  component byte
m_axis_tuser  out  2  component tag: 0=Y, 1=Cr, 2=Cb
m_axis_tlast  out  1  Cb beat of final pixel
s_axis_tvalid  in  1  beat from core valid
s_axis_tready  out  1  ready to core
s_axis_tdata  in  8  component byte from core
m_pix_tvalid  out  1  reassembled pixel valid
m_pix_tready  in  1  sink ready
m_pix_tdata  out  24  {Y, Cr, Cb}
m_pix_tlast  out  1  final pixel of frame

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0; tx_state=TX_IDLE; rx_phase=0; tx_cnt=rx_cnt=0; busy=0. Applies immediately mid-frame. In-flight pixels are discarded, with no tlast and no done.
- Handshake: a transfer occurs on a cycle with valid&&ready. A valid, once raised, holds until accepted, with data/tag/last stable.
- Frame control:
  - start with busy=0 → busy=1 next cycle; tx_cnt and rx_cnt cleared.
  - start with busy=1 → ignored.
  - busy falls in the same cycle done pulses.
- TX FSM: TX_IDLE, TX_Y, TX_CR, TX_CB.
  - s_pix_tready = busy && tx_cnt<PIXELS && (tx_state==TX_IDLE || (tx_state==TX_CB && m_axis_tready)).
  - On pixel accept: latch the pixel into pix_reg, tx_cnt++, go to TX_Y.
  - TX_Y→TX_CR→TX_CB advance on each m_axis handshake. TX_CB goes to TX_Y if a new pixel is accepted in the same cycle, else to TX_IDLE.
  - m_axis_tvalid=1 in TX_Y/TX_CR/TX_CB. tdata selects pix_reg[23:16]/[15:8]/[7:0]; tuser = 0/1/2.
  - m_axis_tlast=1 only in TX_CB when the pixel is the PIXELS-th.
  - Sustained throughput is 3 cycles/pixel with no bubble. First beat appears 1 cycle after pixel accept.
- RX: rx_phase 0,1,2.
  - Phase 0 stores the beat to y_reg; phase 1 stores it to cr_reg.
  - Phase 2 loads m_pix_tdata={y_reg,cr_reg,s_axis_tdata}, sets m_pix_tvalid, rx_cnt++.
  - Phase wraps 2→0.
  - s_axis_tready = busy && (rx_phase!=2 || !m_pix_tvalid || m_pix_tready). Single output register, so full throughput is kept when the sink stays ready.
  - m_pix_tlast=1 with the pixel where rx_cnt reaches PIXELS.
  - done pulses the cycle after that pixel's m_pix handshake.
- Beats from the core arriving while busy=0 are not accepted (tready=0).
- No arithmetic beyond counters. Counters do not wrap within a frame. tx stops accepting at PIXELS.

Test Plan:
- PIXELS=4, rst then start, source pixels 0x102030,0x405060,0x708090,0xA0B0C0, core loopback, tready=1 → m_axis bytes 10,20,30,40,...,C0 with tuser 0,1,2 repeating. tlast only on byte C0. Beats back-to-back (12 consecutive cycles). m_pix outputs equal inputs in order. tlast on 0xA0B0C0. done one pulse, busy 0 after.
- m_axis_tready toggled 1,0 each cycle → byte order unchanged, no duplicates or drops. s_pix_tready asserted only in TX_IDLE or on a completing Cb beat.
- m_pix_tready held 0 after first pixel → s_axis_tready drops at the next phase-2 beat. Release → pixel 2 delivered intact, total 4 pixels, done once.
- start asserted again while busy → no effect on counters. A start after done → new frame of 4 pixels, tx_cnt and rx_cnt restart at 0.
- rst pulsed after 5 beats sent → next cycle all valids/busy/done 0 and tx_state idle. A following start runs a clean 4-pixel frame from Y.
- No start, s_pix_tvalid=1 → s_pix_tready stays 0, m_axis_tvalid stays 0.
